// File: rtl/frame_reader.sv
// frame_reader: scans the 1024x768x32bpp frame out of DDR via the af/rdf
// FIFO pair, buffers returned 128-bit words and streams 24-bit RGB pixels
// in raster order over a valid/ready handshake.
module frame_reader #(
   parameter int FIFO_DEPTH = 64,
   parameter int FILL_WORDS = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  frame_base,
   input  logic         af_full,
   output logic [2:0]   af_cmd_din,
   output logic [30:0]  af_addr_din,
   output logic         af_wr_en,
   input  logic         rdf_valid,
   input  logic [127:0] rdf_dout,
   output logic         rdf_rd_en,
   output logic [23:0]  video,
   output logic         video_valid,
   input  logic         video_ready,
   output logic         video_sof,
   output logic         underflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int UW = CW + 1;
   localparam logic [UW-1:0] CREDIT_MAX = UW'(FIFO_DEPTH - 2);
   localparam logic [CW-1:0] FILL_LIM   = CW'(FILL_WORDS);
   localparam logic [CW-1:0] TWO        = CW'(2);

   typedef enum logic {S_FILL, S_STREAM} state_t;

   state_t         state, state_nxt;
   logic [95:0]    mem [FIFO_DEPTH];
   logic [95:0]    head;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  occ, outstanding;
   logic [UW-1:0]  used;
   logic [1:0]     pix_idx;
   logic [23:0]    pix_sel;
   logic [6:0]     req_xb;
   logic [9:0]     req_y;
   logic [9:0]     px, py;
   logic           credit_ok, push, pop, fire;
   logic           unused_bits;

   // Byte 3 of each pixel is never shown; only the RGB bytes are kept.
   assign unused_bits = ^{frame_base[21:0], rdf_dout[127:120], rdf_dout[95:88],
                          rdf_dout[63:56], rdf_dout[31:24]};

   assign af_cmd_din  = 3'b001;
   assign used        = {1'b0, occ} + {1'b0, outstanding};
   assign credit_ok   = (used <= CREDIT_MAX);
   // Outputs are forced low while reset is held so the bus sees no request.
   assign af_wr_en    = credit_ok & ~af_full & ~rst;
   assign af_addr_din = rst ? '0 : {2'b00, frame_base[31:22], req_y, req_xb, 2'b00};
   assign rdf_rd_en   = rdf_valid & ~rst;
   assign push        = rdf_rd_en;
   assign fire        = video_valid & video_ready;
   assign pop         = fire & (pix_idx == 2'd3);
   assign video       = video_valid ? pix_sel : '0;
   assign video_sof   = video_valid && (px == '0) && (py == '0);

   // Next-state and stream-valid decode.
   always_comb begin
      state_nxt   = state;
      video_valid = 1'b0;
      case (state)
         S_FILL:   if (occ >= FILL_LIM) state_nxt = S_STREAM;
         S_STREAM: video_valid = (occ != '0);
         default:  state_nxt = S_FILL;
      endcase
   end

   // Select the current pixel of the head word, left-most pixel first.
   always_comb begin
      head = mem[rd_ptr];
      case (pix_idx)
         2'd0:    pix_sel = head[95:72];
         2'd1:    pix_sel = head[71:48];
         2'd2:    pix_sel = head[47:24];
         default: pix_sel = head[23:0];
      endcase
   end

   // Pixel buffer storage: RGB bytes of each popped rdf word.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {rdf_dout[119:96], rdf_dout[87:64],
                                rdf_dout[55:32], rdf_dout[23:0]};
   end

   // State register, buffer pointers and credit counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_FILL;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         outstanding <= '0;
         pix_idx     <= '0;
         underflow   <= 1'b0;
      end else begin
         state       <= state_nxt;
         wr_ptr      <= wr_ptr + AW'(push);
         rd_ptr      <= rd_ptr + AW'(pop);
         occ         <= occ + CW'(push) - CW'(pop);
         outstanding <= outstanding + (af_wr_en ? TWO : '0) - CW'(push);
         pix_idx     <= pix_idx + 2'(fire);
         if (state == S_STREAM && occ == '0) underflow <= 1'b1;
      end
   end

   // Request counter: burst column, then line, wrapping at the frame end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_xb <= '0;
         req_y  <= '0;
      end else if (af_wr_en) begin
         req_xb <= req_xb + 7'd1;
         if (req_xb == 7'd127) req_y <= (req_y == 10'd767) ? '0 : req_y + 10'd1;
      end
   end

   // Output pixel position, advanced on every accepted pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         px <= '0;
         py <= '0;
      end else if (fire) begin
         if (px == 10'd1023) begin
            px <= '0;
            py <= (py == 10'd767) ? '0 : py + 10'd1;
         end else begin
            px <= px + 10'd1;
         end
      end
   end

endmodule
